// File: rtl/kv_pkg.sv
// Shared definitions for the kv_io_cmd pad-to-request bridge: op codes, FSM states,
// default widths and the strobe priority helper.
package kv_pkg;

    localparam int KEY_W_DEF          = 7;
    localparam int VAL_W_DEF          = 7;
    localparam int SYNC_STAGES_DEF    = 2;
    localparam int TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        OP_GET = 2'b00,
        OP_PUT = 2'b01,
        OP_DEL = 2'b10,
        OP_CLR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    // Strobe vector is packed {clr, del, put, get}, so the winning bit index is the op code.
    function automatic op_t pick_op(input logic [3:0] edges);
        if (edges[3])      return OP_CLR;
        else if (edges[2]) return OP_DEL;
        else if (edges[1]) return OP_PUT;
        else               return OP_GET;
    endfunction

endpackage

// File: rtl/kv_sync_edge.sv
// Pad synchronisers: kv_sync is a plain multi-flop synchroniser, kv_sync_edge adds a
// registered rising-edge detector on top of it.
module kv_sync #(
    parameter int W     = 1,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] sync_p [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sync_p[i] <= '0;
        end else begin
            sync_p[0] <= d;
            for (int i = 1; i < DEPTH; i++) sync_p[i] <= sync_p[i-1];
        end
    end

    assign q = sync_p[DEPTH-1];
endmodule

module kv_sync_edge #(
    parameter int W     = 1,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);
    logic [W-1:0] sync_q;
    logic [W-1:0] prev_q;

    kv_sync #(.W(W), .DEPTH(DEPTH)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .q     (sync_q)
    );

    // prev resets to 0, so a strobe held high across reset release yields exactly one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= '0;
            rise   <= '0;
        end else begin
            prev_q <= sync_q;
            rise   <= sync_q & ~prev_q;
        end
    end
endmodule

// File: rtl/kv_io_cmd.sv
// Pad command front-end: synchronises raw pad strobes/buses and issues one KV request at a time.
// Optional response timeout enabled with `define KV_IO_TIMEOUT_EN.
module kv_io_cmd
    import kv_pkg::*;
#(
    parameter int KEY_W          = KEY_W_DEF,
    parameter int VAL_W          = VAL_W_DEF,
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic [KEY_W-1:0] io_key_i,
    input  logic [VAL_W-1:0] io_val_i,
    input  logic             io_put_i,
    input  logic             io_get_i,
    input  logic             io_del_i,
    input  logic             io_clr_i,
    output logic             req_valid_o,
    input  logic             req_ready_i,
    output logic [1:0]       req_op_o,
    output logic [KEY_W-1:0] req_key_o,
    output logic [VAL_W-1:0] req_val_o,
    input  logic             rsp_valid_i,
    input  logic             rsp_hit_i,
    input  logic [VAL_W-1:0] rsp_data_i,
    output logic [VAL_W-1:0] io_rdata_o,
    output logic             io_hit_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [7:0]       drop_cnt_o
);
    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("kv_io_cmd: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic [3:0]       cmd_rise;
    logic [KEY_W-1:0] key_s;
    logic [VAL_W-1:0] val_s;
    logic             any_edge;
    op_t              edge_op;

    state_t           state;
    op_t              op_q;
    logic             req_valid_q;
    logic [KEY_W-1:0] key_q;
    logic [VAL_W-1:0] val_q;
    logic [VAL_W-1:0] rdata_q;
    logic             hit_q;
    logic [7:0]       drop_q;

    kv_sync_edge #(.W(4), .DEPTH(SYNC_STAGES)) u_cmd_sync (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .d     ({io_clr_i, io_del_i, io_put_i, io_get_i}),
        .rise  (cmd_rise)
    );

    kv_sync #(.W(KEY_W + VAL_W), .DEPTH(SYNC_STAGES)) u_data_sync (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .d     ({io_key_i, io_val_i}),
        .q     ({key_s, val_s})
    );

    assign any_edge = |cmd_rise;
    assign edge_op  = pick_op(cmd_rise);

`ifdef KV_IO_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state       <= ST_IDLE;
            op_q        <= OP_GET;
            req_valid_q <= 1'b0;
            key_q       <= '0;
            val_q       <= '0;
            rdata_q     <= '0;
            hit_q       <= 1'b0;
            drop_q      <= '0;
`ifdef KV_IO_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            // Only the winning edge of a cycle counts as a drop; a CLR response below overrides.
            if (state != ST_IDLE && any_edge && drop_q != 8'hFF)
                drop_q <= drop_q + 8'd1;

            case (state)
                ST_IDLE: begin
                    if (any_edge) begin
                        op_q        <= edge_op;
                        key_q       <= key_s;
                        val_q       <= val_s;
                        req_valid_q <= 1'b1;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (req_valid_q && req_ready_i) begin
                        req_valid_q <= 1'b0;
                        state       <= ST_WAIT;
`ifdef KV_IO_TIMEOUT_EN
                        tmo_q       <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (rsp_valid_i) begin
                        hit_q <= rsp_hit_i;
                        if (op_q == OP_GET) rdata_q <= rsp_data_i;
                        if (op_q == OP_CLR) begin
                            drop_q <= '0;
`ifdef KV_IO_TIMEOUT_EN
                            err_q  <= 1'b0;
`endif
                        end
                        state <= ST_IDLE;
                    end
`ifdef KV_IO_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        err_q <= 1'b1;
                        hit_q <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_valid_o = req_valid_q;
    assign req_op_o    = op_q;
    assign req_key_o   = key_q;
    assign req_val_o   = val_q;
    assign io_rdata_o  = rdata_q;
    assign io_hit_o    = hit_q;
    assign busy_o      = (state != ST_IDLE);
    assign drop_cnt_o  = drop_q;
`ifdef KV_IO_TIMEOUT_EN
    assign err_o       = err_q;
`else
    assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_kv_io_cmd.sv
// Scoreboard bench for kv_io_cmd: expected requests/responses are queued by the stimulus
// and checked by a monitor on each handshake and each busy->idle transition.
module tb_kv_io_cmd;
    localparam int KEY_W = 7;
    localparam int VAL_W = 7;

    typedef struct packed {
        logic [1:0] op;
        logic [6:0] key;
        logic [6:0] val;
    } req_t;

    typedef struct packed {
        logic       hit;
        logic [6:0] rdata;
        logic [7:0] drop;
        logic       err;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [KEY_W-1:0] io_key;
    logic [VAL_W-1:0] io_val;
    logic             io_put, io_get, io_del, io_clr;
    logic             req_valid, req_ready;
    logic [1:0]       req_op;
    logic [KEY_W-1:0] req_key;
    logic [VAL_W-1:0] req_val;
    logic             rsp_valid, rsp_hit;
    logic [VAL_W-1:0] rsp_data;
    logic [VAL_W-1:0] io_rdata;
    logic             io_hit, busy, err;
    logic [7:0]       drop_cnt;

    req_t req_q[$];
    rsp_t rsp_q[$];
    req_t re;
    rsp_t se;
    int   checks = 0;
    int   errors = 0;
    logic prev_busy = 1'b0;
    logic exp_err_tmo;

    always #5 clk = ~clk;

    kv_io_cmd #(
        .KEY_W(KEY_W), .VAL_W(VAL_W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .io_key_i    (io_key),
        .io_val_i    (io_val),
        .io_put_i    (io_put),
        .io_get_i    (io_get),
        .io_del_i    (io_del),
        .io_clr_i    (io_clr),
        .req_valid_o (req_valid),
        .req_ready_i (req_ready),
        .req_op_o    (req_op),
        .req_key_o   (req_key),
        .req_val_o   (req_val),
        .rsp_valid_i (rsp_valid),
        .rsp_hit_i   (rsp_hit),
        .rsp_data_i  (rsp_data),
        .io_rdata_o  (io_rdata),
        .io_hit_o    (io_hit),
        .busy_o      (busy),
        .err_o       (err),
        .drop_cnt_o  (drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Monitor: request handshakes and response completions, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                if (req_q.size() == 0) begin
                    bound_fail("req_unexpected");
                end else begin
                    re = req_q.pop_front();
                    chk("req_op", req_op, re.op);
                    chk("req_key", req_key, re.key);
                    chk("req_val", req_val, re.val);
                end
            end
            if (prev_busy && !busy) begin
                if (rsp_q.size() == 0) begin
                    bound_fail("rsp_unexpected");
                end else begin
                    se = rsp_q.pop_front();
                    chk("rsp_hit", io_hit, se.hit);
                    chk("rsp_rdata", io_rdata, se.rdata);
                    chk("rsp_drop", drop_cnt, se.drop);
                    chk("rsp_err", err, se.err);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] m);
        {io_clr, io_del, io_put, io_get} = m;
        tick();
        {io_clr, io_del, io_put, io_get} = 4'b0000;
    endtask

    task automatic wait_wait();
        int n = 0;
        while (!(busy && !req_valid) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) bound_fail("wait_state");
    endtask

    task automatic send_rsp(input logic hit, input logic [6:0] data);
        rsp_valid = 1'b1;
        rsp_hit   = hit;
        rsp_data  = data;
        tick();
        rsp_valid = 1'b0;
        rsp_hit   = 1'b0;
        rsp_data  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
`ifdef KV_IO_TIMEOUT_EN
        exp_err_tmo = 1'b1;
`else
        exp_err_tmo = 1'b0;
`endif
        rst_n = 1'b0;
        req_ready = 1'b1;
        rsp_valid = 1'b0; rsp_hit = 1'b0; rsp_data = '0;
        io_key = '0; io_val = '0;
        {io_clr, io_del, io_put, io_get} = 4'b0000;

        // Reset with pads toggling
        for (int i = 0; i < 6; i++) begin
            io_key = 7'($urandom); io_val = 7'($urandom);
            {io_clr, io_del, io_put, io_get} = 4'($urandom);
            tick();
            chk("rst_req_valid", req_valid, 0);
            chk("rst_busy", busy, 0);
        end
        chk("rst_op", req_op, 0);
        chk("rst_key", req_key, 0);
        chk("rst_val", req_val, 0);
        chk("rst_rdata", io_rdata, 0);
        chk("rst_hit", io_hit, 0);
        chk("rst_err", err, 0);
        chk("rst_drop", drop_cnt, 0);
        {io_clr, io_del, io_put, io_get} = 4'b0000;
        io_key = '0; io_val = '0;
        tick();
        rst_n = 1'b1;
        tick(); tick();

        // PUT with latency check
        io_key = 7'h15; io_val = 7'h2A;
        req_q.push_back('{op: 2'b01, key: 7'h15, val: 7'h2A});
        rsp_q.push_back('{hit: 1'b1, rdata: 7'h00, drop: 8'd0, err: 1'b0});
        io_put = 1'b1;
        tick();
        io_put = 1'b0;
        tick(); tick();
        chk("put_lat_early", req_valid, 0);
        tick();
        chk("put_lat_cycle3", req_valid, 1);
        wait_wait();
        tick();
        send_rsp(1'b1, 7'h33);
        chk("put_busy_after", busy, 0);
        chk("put_rdata_held", io_rdata, 7'h00);

        // GET with 5 cycles of backpressure
        req_ready = 1'b0;
        io_key = 7'h07; io_val = 7'h11;
        req_q.push_back('{op: 2'b00, key: 7'h07, val: 7'h11});
        rsp_q.push_back('{hit: 1'b1, rdata: 7'h55, drop: 8'd0, err: 1'b0});
        pulse(4'b0001);
        n = 0;
        while (!req_valid && n < 20) begin tick(); n++; end
        if (n >= 20) bound_fail("get_req_valid");
        io_key = 7'h7F; io_val = 7'h7F;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", req_valid, 1);
            chk("bp_op", req_op, 2'b00);
            chk("bp_key", req_key, 7'h07);
            chk("bp_val", req_val, 7'h11);
            tick();
        end
        req_ready = 1'b1;
        tick();
        wait_wait();
        send_rsp(1'b1, 7'h55);
        chk("get_rdata", io_rdata, 7'h55);
        chk("get_hit", io_hit, 1);

        // Simultaneous PUT and DEL: DEL wins, nothing counted as dropped
        io_key = 7'h0A; io_val = 7'h0B;
        req_q.push_back('{op: 2'b10, key: 7'h0A, val: 7'h0B});
        rsp_q.push_back('{hit: 1'b0, rdata: 7'h55, drop: 8'd0, err: 1'b0});
        pulse(4'b0110);
        wait_wait();
        send_rsp(1'b0, 7'h12);
        chk("prio_drop", drop_cnt, 0);

        // Three edges while waiting, then a CLR clears the drop count
        io_key = 7'h01; io_val = 7'h00;
        req_q.push_back('{op: 2'b00, key: 7'h01, val: 7'h00});
        rsp_q.push_back('{hit: 1'b1, rdata: 7'h66, drop: 8'd3, err: 1'b0});
        pulse(4'b0001);
        wait_wait();
        pulse(4'b0010); tick(); tick();
        pulse(4'b0100); tick(); tick();
        pulse(4'b0001);
        repeat (5) tick();
        chk("drop_three", drop_cnt, 3);
        send_rsp(1'b1, 7'h66);
        io_key = 7'h02; io_val = 7'h03;
        req_q.push_back('{op: 2'b11, key: 7'h02, val: 7'h03});
        rsp_q.push_back('{hit: 1'b0, rdata: 7'h66, drop: 8'd0, err: 1'b0});
        pulse(4'b1000);
        wait_wait();
        send_rsp(1'b0, 7'h44);
        chk("clr_drop", drop_cnt, 0);

        // Response timeout (err stays 0 when the timeout is not built in)
        io_key = 7'h04; io_val = 7'h05;
        req_q.push_back('{op: 2'b01, key: 7'h04, val: 7'h05});
        rsp_q.push_back('{hit: 1'b1, rdata: 7'h66, drop: 8'd0, err: 1'b0});
        pulse(4'b0010);
        wait_wait();
        send_rsp(1'b1, 7'h00);
        chk("pre_tmo_hit", io_hit, 1);
`ifdef KV_IO_TIMEOUT_EN
        io_key = 7'h03; io_val = 7'h00;
        req_q.push_back('{op: 2'b00, key: 7'h03, val: 7'h00});
        rsp_q.push_back('{hit: 1'b0, rdata: 7'h66, drop: 8'd0, err: 1'b1});
        pulse(4'b0001);
        wait_wait();
        n = 0;
        while (busy && n < 40) begin tick(); n++; end
        chk("tmo_wait_cycles", n, 8);
        chk("tmo_err", err, 1);
        chk("tmo_hit", io_hit, 0);
        send_rsp(1'b1, 7'h77);
        tick();
        chk("late_hit", io_hit, 0);
        chk("late_rdata", io_rdata, 7'h66);
        chk("late_busy", busy, 0);
        req_q.push_back('{op: 2'b11, key: 7'h03, val: 7'h00});
        rsp_q.push_back('{hit: 1'b0, rdata: 7'h66, drop: 8'd0, err: 1'b0});
        pulse(4'b1000);
        wait_wait();
        send_rsp(1'b0, 7'h00);
`endif
        chk("err_final", err, 0);
        chk("err_mode_known", {31'd0, exp_err_tmo} | {31'd0, err}, {31'd0, exp_err_tmo});

        repeat (3) tick();
        chk("req_q_empty", req_q.size(), 0);
        chk("rsp_q_empty", rsp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
